jt900h_flags: RTL

Flag register unit of the JT900H core. It sits on the other end of the ALU's flag interface: it captures the S/Z/H/V/N/C results from the ALU under per-flag write masks and holds them in the architectural F register plus its alternate bank F'. It feeds the stored flags back to the ALU as carry/half-carry/sign/zero inputs and evaluates the 16 TLCS-900H condition codes for jumps, calls and returns.

---
 rtl/jt900h_pkg.sv | 70 +++++++
 rtl/jt900h_cc.sv | 35 +++
 rtl/jt900h_flags.sv | 107 ++++++++++
 3 files changed

// File: rtl/jt900h_pkg.sv
// Shared flag-register definitions for the JT900H core: bit positions in the F byte,
// carry-flag op encodings, condition codes and F-byte pack/unpack helpers.
package jt900h_pkg;

    localparam int FS = 7;
    localparam int FZ = 6;
    localparam int FH = 4;
    localparam int FV = 2;
    localparam int FN = 1;
    localparam int FC = 0;

    typedef enum logic [2:0] {
        FOP_NONE = 3'd0,
        FOP_RCF  = 3'd1,
        FOP_SCF  = 3'd2,
        FOP_CCF  = 3'd3,
        FOP_ZCF  = 3'd4
    } flag_op_e;

    localparam logic [3:0] CC_F   = 4'd0;
    localparam logic [3:0] CC_LT  = 4'd1;
    localparam logic [3:0] CC_LE  = 4'd2;
    localparam logic [3:0] CC_ULE = 4'd3;
    localparam logic [3:0] CC_OV  = 4'd4;
    localparam logic [3:0] CC_MI  = 4'd5;
    localparam logic [3:0] CC_Z   = 4'd6;
    localparam logic [3:0] CC_C   = 4'd7;
    localparam logic [3:0] CC_T   = 4'd8;
    localparam logic [3:0] CC_GE  = 4'd9;
    localparam logic [3:0] CC_GT  = 4'd10;
    localparam logic [3:0] CC_UGT = 4'd11;
    localparam logic [3:0] CC_NOV = 4'd12;
    localparam logic [3:0] CC_PL  = 4'd13;
    localparam logic [3:0] CC_NZ  = 4'd14;
    localparam logic [3:0] CC_NC  = 4'd15;

    // Field order matches upd_mask so a mask merge is a plain bitwise operation.
    typedef struct packed {
        logic s;
        logic z;
        logic h;
        logic v;
        logic n;
        logic c;
    } flags_t;

    function automatic logic [7:0] flags_to_byte(input flags_t fl);
        logic [7:0] b;
        b     = 8'h00;
        b[FS] = fl.s;
        b[FZ] = fl.z;
        b[FH] = fl.h;
        b[FV] = fl.v;
        b[FN] = fl.n;
        b[FC] = fl.c;
        return b;
    endfunction

    function automatic flags_t byte_to_flags(input logic [7:0] b);
        flags_t fl;
        fl.s = b[FS];
        fl.z = b[FZ];
        fl.h = b[FH];
        fl.v = b[FV];
        fl.n = b[FN];
        fl.c = b[FC];
        return fl;
    endfunction

endpackage

// File: rtl/jt900h_cc.sv
// TLCS-900H condition-code evaluator; purely combinational, no state, no flow control.
// Shared with the sequencer for DJNZ/JR decisions.
module jt900h_cc
    import jt900h_pkg::*;
(
    input  logic [3:0] cc,
    input  logic       s,
    input  logic       z,
    input  logic       v,
    input  logic       c,
    output logic       ok
);

    logic lt;
    logic base;

    always_comb begin
        lt   = s ^ v;
        base = 1'b0;
        // Codes 8..15 are the complements of 0..7, so only the low half is decoded.
        case (cc[2:0])
            CC_F[2:0]:   base = 1'b0;
            CC_LT[2:0]:  base = lt;
            CC_LE[2:0]:  base = lt | z;
            CC_ULE[2:0]: base = c | z;
            CC_OV[2:0]:  base = v;
            CC_MI[2:0]:  base = s;
            CC_Z[2:0]:   base = z;
            CC_C[2:0]:   base = c;
            default:     base = 1'b0;
        endcase
        ok = base ^ cc[3];
    end

endmodule

// File: rtl/jt900h_flags.sv
// F/F' flag register bank with prioritized load/exchange/carry-op/ALU-mask updates.
// Results visible one cen cycle after the strobe; no backpressure, only cc->cc_ok is combinational.
module jt900h_flags
    import jt900h_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       alu_s,
    input  logic       alu_z,
    input  logic       alu_h,
    input  logic       alu_v,
    input  logic       alu_n,
    input  logic       alu_c,
    input  logic [5:0] upd_mask,
    input  logic [2:0] flag_op,
    input  logic       ld_f,
    input  logic [7:0] din,
    input  logic       ex_ff,
    input  logic [3:0] cc,
    output logic [7:0] f,
    output logic [7:0] f_alt,
    output logic       sin,
    output logic       zin,
    output logic       hin,
    output logic       vin,
    output logic       nin,
    output logic       cin,
    output logic       cc_ok
);

    flags_t fm_q, fm_d;
    flags_t fa_q, fa_d;
    flags_t alu_flags;
    flags_t din_flags;

    always_comb begin
        alu_flags = '{s: alu_s, z: alu_z, h: alu_h, v: alu_v, n: alu_n, c: alu_c};
        din_flags = byte_to_flags(din);
    end

    // One action per cycle; lower-priority requests in the same cycle are dropped.
    always_comb begin
        fm_d = fm_q;
        fa_d = fa_q;
        if (ld_f) begin
            fm_d = din_flags;
        end else if (ex_ff) begin
            fm_d = fa_q;
            fa_d = fm_q;
        end else if (flag_op inside {FOP_RCF, FOP_SCF, FOP_CCF, FOP_ZCF}) begin
            case (flag_op)
                FOP_RCF: begin
                    fm_d.c = 1'b0;
                    fm_d.h = 1'b0;
                    fm_d.n = 1'b0;
                end
                FOP_SCF: begin
                    fm_d.c = 1'b1;
                    fm_d.h = 1'b0;
                    fm_d.n = 1'b0;
                end
                FOP_CCF: begin
                    fm_d.c = ~fm_q.c;
                    fm_d.n = 1'b0;
                end
                default: begin
                    fm_d.c = ~fm_q.z;
                    fm_d.n = 1'b0;
                end
            endcase
        end else if (upd_mask != 6'd0) begin
            fm_d = (fm_q & ~upd_mask) | (alu_flags & upd_mask);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fm_q <= '0;
            fa_q <= '0;
        end else if (cen) begin
            fm_q <= fm_d;
            fa_q <= fa_d;
        end
    end

    always_comb begin
        f     = flags_to_byte(fm_q);
        f_alt = flags_to_byte(fa_q);
        sin   = fm_q.s;
        zin   = fm_q.z;
        hin   = fm_q.h;
        vin   = fm_q.v;
        nin   = fm_q.n;
        cin   = fm_q.c;
    end

    jt900h_cc u_cc (
        .cc (cc),
        .s  (fm_q.s),
        .z  (fm_q.z),
        .v  (fm_q.v),
        .c  (fm_q.c),
        .ok (cc_ok)
    );

endmodule
